// File: rtl/fetch_line_queue.sv
// Instruction fetch queue: buffers whole i-cache lines and unpacks them into an in-order
// one-instruction-per-cycle stream. Define FETCH_QUEUE_BYPASS_EN for zero-latency hand-off when empty.
module fetch_line_queue #(
    parameter int XLEN       = 32,
    parameter int ILEN       = 32,
    parameter int LINE_INSTR = 4,
    parameter int DEPTH      = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  logic                       line_valid_i,
    output logic                       line_ready_o,
    input  logic [XLEN-1:0]            line_pc_i,
    input  logic [LINE_INSTR*ILEN-1:0] line_i,
    output logic                       issue_valid_o,
    input  logic                       issue_ready_i,
    output logic [ILEN-1:0]            instruction_o,
    output logic [XLEN-1:0]            instr_pc_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int OFFW = $clog2(LINE_INSTR);
    localparam int BOFF = $clog2(ILEN / 8);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int PCHW = XLEN - OFFW - BOFF;

    typedef logic [LINE_INSTR-1:0][ILEN-1:0] line_t;

    line_t           line_mem [DEPTH];
    logic [PCHW-1:0] pc_mem   [DEPTH];
    logic [OFFW-1:0] idx_mem  [DEPTH];

    logic [PTRW-1:0] head;
    logic [PTRW-1:0] tail;
    logic [CNTW-1:0] count;

    line_t           in_words;
    logic [OFFW-1:0] in_off;
    logic [OFFW-1:0] push_idx;
    logic [OFFW-1:0] head_idx;
    logic [ILEN-1:0] head_instr;
    logic [XLEN-1:0] head_pc;
    logic            empty;
    logic            full;
    logic            bypass;
    logic            push;
    logic            pop;
    logic            free_head;

    assign in_words = line_i;
    assign in_off   = line_pc_i[BOFF +: OFFW];
    assign empty    = (count == '0);
    assign full     = (count == CNTW'(DEPTH));

    assign head_idx   = idx_mem[head];
    assign head_instr = line_mem[head][head_idx];
    assign head_pc    = XLEN'({pc_mem[head], head_idx}) << BOFF;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty && line_valid_i && !flush_i;
`else
    assign bypass = 1'b0;
`endif

    // Byte-offset bits of the fetch PC never select anything.
    generate
        if (BOFF > 0) begin : g_byte_bits
            logic unused_byte_bits;
            assign unused_byte_bits = ^line_pc_i[BOFF-1:0];
        end
    endgenerate

    assign line_ready_o = !full;
    assign count_o      = count;

    assign pop       = !empty && !flush_i && issue_ready_i;
    assign free_head = pop && (head_idx == OFFW'(LINE_INSTR - 1));

    // A line consumed in bypass is stored past the word already issued, or not at all.
    always_comb begin
        push     = line_valid_i && !full && !flush_i;
        push_idx = in_off;
        if (bypass && issue_ready_i) begin
            push_idx = in_off + OFFW'(1);
            if (in_off == OFFW'(LINE_INSTR - 1)) begin
                push = 1'b0;
            end
        end
    end

    always_comb begin
        issue_valid_o = 1'b0;
        instruction_o = '0;
        instr_pc_o    = '0;
        if (bypass) begin
            issue_valid_o = 1'b1;
            instruction_o = in_words[in_off];
            instr_pc_o    = (line_pc_i >> BOFF) << BOFF;
        end else if (!empty) begin
            issue_valid_o = !flush_i;
            instruction_o = head_instr;
            instr_pc_o    = head_pc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_mem[i] <= '0;
            end
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail          <= tail + PTRW'(1);
                idx_mem[tail] <= push_idx;
            end
            if (pop) begin
                if (free_head) begin
                    head <= head + PTRW'(1);
                end else begin
                    idx_mem[head] <= head_idx + OFFW'(1);
                end
            end
            if (push && !free_head) begin
                count <= count + CNTW'(1);
            end else if (!push && free_head) begin
                count <= count - CNTW'(1);
            end
        end
    end

    // Line payload carries no reset; only entries below count are ever read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            line_mem[tail] <= in_words;
            pc_mem[tail]   <= line_pc_i[XLEN-1 -: PCHW];
        end
    end

endmodule

// File: tb/tb_fetch_line_queue.sv
// Self-checking bench for fetch_line_queue: directed vector table, hand-written corner
// sequences and randomized traffic against an instruction-stream reference model.
module tb_fetch_line_queue;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         line_valid = 1'b0;
    logic         line_ready;
    logic [31:0]  line_pc = '0;
    logic [127:0] line = '0;
    logic         issue_valid;
    logic         issue_ready = 1'b0;
    logic [31:0]  instruction;
    logic [31:0]  instr_pc;
    logic [2:0]   count;

`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    fetch_line_queue #(.XLEN(32), .ILEN(32), .LINE_INSTR(4), .DEPTH(4)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .flush_i       (flush),
        .line_valid_i  (line_valid),
        .line_ready_o  (line_ready),
        .line_pc_i     (line_pc),
        .line_i        (line),
        .issue_valid_o (issue_valid),
        .issue_ready_i (issue_ready),
        .instruction_o (instruction),
        .instr_pc_o    (instr_pc),
        .count_o       (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the pending instruction stream, each word tagged with its line id.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        int          lid;
    } ent_t;
    ent_t q[$];
    int   next_lid = 0;

    typedef struct {
        logic        lv;
        logic [31:0] pc;
        logic [31:0] base;
        logic        ir;
        logic        fl;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        int          ec;
        logic        er;
    } vec_t;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int lines_held();
        int n = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (i == 0 || q[i].lid != q[i-1].lid) n++;
        end
        return n;
    endfunction

    function automatic logic [127:0] mkline(input logic [31:0] b);
        return {b + 32'd4, b + 32'd3, b + 32'd2, b + 32'd1};
    endfunction

    function automatic vec_t mkv(input logic lv, input logic [31:0] pc, input logic [31:0] base,
                                 input logic ir, input logic fl, input logic ev,
                                 input logic [31:0] ei, input logic [31:0] ep, input int ec,
                                 input logic er);
        vec_t v;
        v.lv = lv; v.pc = pc; v.base = base; v.ir = ir; v.fl = fl;
        v.ev = ev; v.ei = ei; v.ep = ep; v.ec = ec; v.er = er;
        return v;
    endfunction

    // One clock cycle: drive at the falling edge, check settled outputs, advance the model.
    task automatic step(input logic lv, input logic [31:0] pc, input logic [127:0] data,
                        input logic ir, input logic fl, output logic acc);
        int   mc;
        logic er;
        logic ev;
        logic byp;
        @(negedge clk);
        line_valid  = lv;
        line_pc     = pc;
        line        = data;
        issue_ready = ir;
        flush       = fl;
        #1;
        mc  = lines_held();
        er  = (mc < 4);
        byp = BYP && (mc == 0) && lv && !fl;
        ev  = ((mc != 0) && !fl) || byp;
        chk("count", 64'(count), 64'(mc));
        chk("line_ready", 64'(line_ready), 64'(er));
        chk("issue_valid", 64'(issue_valid), 64'(ev));
        acc = lv && er && !fl;
        if (fl) begin
            q.delete();
        end else begin
            if (acc) begin
                for (int k = int'(pc[3:2]); k < 4; k++) begin
                    q.push_back('{data[32*k +: 32], {pc[31:4], k[1:0], 2'b00}, next_lid});
                end
                next_lid++;
            end
            if (ev) begin
                if (q.size() == 0) begin
                    chk("stream_nonempty", 64'(0), 64'(1));
                end else begin
                    chk("instruction", 64'(instruction), 64'(q[0].instr));
                    chk("instr_pc", 64'(instr_pc), 64'(q[0].pc));
                    if (ir) void'(q.pop_front());
                end
            end
        end
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 40 && q.size() != 0; i++) begin
            step(1'b0, 32'h0, 128'h0, 1'b1, 1'b0, a);
        end
        chk("drain_left", 64'(q.size()), 64'(0));
    endtask

    initial begin
        logic acc;
        vec_t tbl[22];

        #1;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_issue_valid", 64'(issue_valid), 64'(0));
        chk("rst_line_ready", 64'(line_ready), 64'(1));
        chk("rst_instruction", 64'(instruction), 64'(0));
        chk("rst_instr_pc", 64'(instr_pc), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

`ifndef FETCH_QUEUE_BYPASS_EN
        // Aligned stream, unaligned fetch, then flush with three lines held.
        tbl[0]  = mkv(1, 32'h00, 32'h00, 1, 0, 0, 32'h0,  32'h00, 0, 1);
        tbl[1]  = mkv(1, 32'h10, 32'h00, 1, 0, 1, 32'h1,  32'h00, 1, 1);
        tbl[2]  = mkv(1, 32'h20, 32'h00, 1, 0, 1, 32'h2,  32'h04, 2, 1);
        tbl[3]  = mkv(0, 32'h00, 32'h00, 1, 0, 1, 32'h3,  32'h08, 3, 1);
        tbl[4]  = mkv(0, 32'h00, 32'h00, 1, 0, 1, 32'h4,  32'h0C, 3, 1);
        tbl[5]  = mkv(0, 32'h00, 32'h00, 1, 0, 1, 32'h1,  32'h10, 2, 1);
        tbl[6]  = mkv(0, 32'h00, 32'h00, 1, 0, 1, 32'h2,  32'h14, 2, 1);
        tbl[7]  = mkv(0, 32'h00, 32'h00, 1, 0, 1, 32'h3,  32'h18, 2, 1);
        tbl[8]  = mkv(0, 32'h00, 32'h00, 1, 0, 1, 32'h4,  32'h1C, 2, 1);
        tbl[9]  = mkv(0, 32'h00, 32'h00, 1, 0, 1, 32'h1,  32'h20, 1, 1);
        tbl[10] = mkv(0, 32'h00, 32'h00, 1, 0, 1, 32'h2,  32'h24, 1, 1);
        tbl[11] = mkv(0, 32'h00, 32'h00, 1, 0, 1, 32'h3,  32'h28, 1, 1);
        tbl[12] = mkv(0, 32'h00, 32'h00, 1, 0, 1, 32'h4,  32'h2C, 1, 1);
        tbl[13] = mkv(1, 32'h18, 32'h00, 1, 0, 0, 32'h0,  32'h00, 0, 1);
        tbl[14] = mkv(0, 32'h00, 32'h00, 1, 0, 1, 32'h3,  32'h18, 1, 1);
        tbl[15] = mkv(0, 32'h00, 32'h00, 1, 0, 1, 32'h4,  32'h1C, 1, 1);
        tbl[16] = mkv(1, 32'h00, 32'h10, 0, 0, 0, 32'h0,  32'h00, 0, 1);
        tbl[17] = mkv(1, 32'h10, 32'h10, 0, 0, 1, 32'h11, 32'h00, 1, 1);
        tbl[18] = mkv(1, 32'h20, 32'h10, 0, 0, 1, 32'h11, 32'h00, 2, 1);
        tbl[19] = mkv(1, 32'h40, 32'h50, 0, 1, 0, 32'h0,  32'h00, 3, 1);
        tbl[20] = mkv(0, 32'h00, 32'h00, 0, 0, 0, 32'h0,  32'h00, 0, 1);
        tbl[21] = mkv(0, 32'h00, 32'h00, 1, 0, 0, 32'h0,  32'h00, 0, 1);
        for (int r = 0; r < 22; r++) begin
            step(tbl[r].lv, tbl[r].pc, mkline(tbl[r].base), tbl[r].ir, tbl[r].fl, acc);
            chk($sformatf("tbl%0d_valid", r), 64'(issue_valid), 64'(tbl[r].ev));
            chk($sformatf("tbl%0d_count", r), 64'(count), 64'(tbl[r].ec));
            chk($sformatf("tbl%0d_ready", r), 64'(line_ready), 64'(tbl[r].er));
            if (tbl[r].ev) begin
                chk($sformatf("tbl%0d_instr", r), 64'(instruction), 64'(tbl[r].ei));
                chk($sformatf("tbl%0d_pc", r), 64'(instr_pc), 64'(tbl[r].ep));
            end
        end
        chk("tbl_empty_instruction", 64'(instruction), 64'(0));
`else
        // Bypass: empty queue, line PC 0x4 issues word 1 in the same cycle.
        step(1'b1, 32'h4, mkline(32'h0), 1'b1, 1'b0, acc);
        chk("byp_valid", 64'(issue_valid), 64'(1));
        chk("byp_instr", 64'(instruction), 64'(2));
        chk("byp_pc", 64'(instr_pc), 64'(4));
        step(1'b0, 32'h0, 128'h0, 1'b1, 1'b0, acc);
        chk("byp_w2", 64'(instruction), 64'(3));
        step(1'b0, 32'h0, 128'h0, 1'b1, 1'b0, acc);
        chk("byp_w3", 64'(instruction), 64'(4));
        step(1'b0, 32'h0, 128'h0, 1'b1, 1'b0, acc);
        chk("byp_done", 64'(issue_valid), 64'(0));
        step(1'b1, 32'h3C, mkline(32'h70), 1'b1, 1'b0, acc);
        chk("byp_last_instr", 64'(instruction), 64'(32'h74));
        step(1'b0, 32'h0, 128'h0, 1'b1, 1'b0, acc);
        chk("byp_last_count", 64'(count), 64'(0));
`endif

        // Backpressure until full; the fifth line is held by the source.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h100 + 32'(i) * 32'h10, mkline(32'h100 + 32'(i) * 32'h10), 1'b0, 1'b0, acc);
        end
        chk("full_count", 64'(count), 64'(4));
        chk("full_ready", 64'(line_ready), 64'(0));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h140, mkline(32'h140), 1'b1, 1'b0, acc);
            chk("full_ready_held", 64'(line_ready), 64'(0));
        end
        step(1'b1, 32'h140, mkline(32'h140), 1'b0, 1'b0, acc);
        chk("freed_ready", 64'(line_ready), 64'(1));
        chk("freed_count", 64'(count), 64'(3));
        drain();

        // Ten lines across pointer wrap with random issue backpressure.
        for (int i = 0; i < 10; i++) begin
            logic [31:0] pc;
            int guard = 0;
            pc  = 32'h200 + 32'(i) * 32'h10 + 32'($urandom_range(0, 3)) * 32'h4;
            acc = 1'b0;
            while (!acc && guard < 100) begin
                step(1'b1, pc, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0, acc);
                guard++;
            end
            if (!acc) chk("wrap_accept_timeout", 64'(0), 64'(1));
        end
        drain();

        // Asynchronous reset with two lines held.
        step(1'b1, 32'h300, mkline(32'h300), 1'b0, 1'b0, acc);
        step(1'b1, 32'h310, mkline(32'h310), 1'b0, 1'b0, acc);
        @(negedge clk);
        line_valid = 1'b0;
        chk("pre_rst_count", 64'(count), 64'(2));
        #1 rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'(0));
        chk("arst_issue_valid", 64'(issue_valid), 64'(0));
        chk("arst_line_ready", 64'(line_ready), 64'(1));
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 128'h0, 1'b1, 1'b0, acc);
        step(1'b0, 32'h0, 128'h0, 1'b1, 1'b0, acc);

        // Randomized traffic including occasional flushes.
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 3) != 0, $urandom, {$urandom, $urandom, $urandom, $urandom},
                 ($urandom % 4) != 0, ($urandom % 40) == 0, acc);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
